// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline controls in, instruction-memory port, IF/ID register and status out.
// master is the fetch stage; slave is the surrounding pipeline and memory.
interface fetch_stage_if;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc_plus4;
   logic [31:0] ifid_instr;
   logic        halted;
   logic        misaligned;

   modport master (
      input  stall, flush, redirect_valid, redirect_pc, imem_instr,
      output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, halted, misaligned
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_pc, imem_instr,
      input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, halted, misaligned
   );
endinterface

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch stage: owns the PC, reads instruction memory combinationally
// and fills the IF/ID register, with stall/flush/redirect control and a post-reset warm-up.
module fetch_stage #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0004,
   parameter int unsigned WARMUP_CYCLES = 1,
   parameter logic [31:0] NOP_INSTR     = 32'h0000_0013
) (
   input logic          clk,
   input logic          reset,
   fetch_stage_if.master bus
);

   localparam logic [1:0]  ST_WARM   = 2'd0;
   localparam logic [1:0]  ST_RUN    = 2'd1;
   localparam logic [1:0]  ST_HALT   = 2'd2;
   localparam logic [3:0]  WARM_LAST = 4'(WARMUP_CYCLES - 1);
   localparam logic [31:0] ECALL     = 32'h0000_0073;
   localparam logic [31:0] EBREAK    = 32'h0010_0073;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] ip4_q, ip4_d;
   logic [31:0] instr_q, instr_d;
   logic        halted_q, halted_d;
   logic        mis_q, mis_d;
   logic        bubble;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      ipc_d    = ipc_q;
      ip4_d    = ip4_q;
      instr_d  = instr_q;
      halted_d = halted_q;
      mis_d    = mis_q;
      bubble   = 1'b0;
      case (state_q)
         ST_WARM: begin
            bubble = 1'b1;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == WARM_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.redirect_valid) begin
               bubble = 1'b1;
               if (bus.redirect_pc[1:0] != 2'b00) begin
                  // Misaligned target: stop fetching rather than jump.
                  mis_d    = 1'b1;
                  halted_d = 1'b1;
                  state_d  = ST_HALT;
               end else begin
                  pc_d = bus.redirect_pc;
               end
            end else if (bus.stall) begin
               // Hold everything.
            end else if (bus.flush) begin
               bubble = 1'b1;
               pc_d   = pc_plus4;
            end else begin
               valid_d = 1'b1;
               ipc_d   = pc_q;
               ip4_d   = pc_plus4;
               instr_d = bus.imem_instr;
               if (bus.imem_instr == ECALL || bus.imem_instr == EBREAK) begin
                  halted_d = 1'b1;
                  state_d  = ST_HALT;
               end else begin
                  pc_d = pc_plus4;
               end
            end
         end
         default: begin
            bubble = 1'b1;
         end
      endcase
      if (bubble) begin
         valid_d = 1'b0;
         ipc_d   = 32'd0;
         ip4_d   = 32'd0;
         instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_WARM;
         cnt_q    <= 4'd0;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         ipc_q    <= 32'd0;
         ip4_q    <= 32'd0;
         instr_q  <= NOP_INSTR;
         halted_q <= 1'b0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         ipc_q    <= ipc_d;
         ip4_q    <= ip4_d;
         instr_q  <= instr_d;
         halted_q <= halted_d;
         mis_q    <= mis_d;
      end
   end

   assign bus.imem_addr     = pc_q;
   assign bus.ifid_valid    = valid_q;
   assign bus.ifid_pc       = ipc_q;
   assign bus.ifid_pc_plus4 = ip4_q;
   assign bus.ifid_instr    = instr_q;
   assign bus.halted        = halted_q;
   assign bus.misaligned    = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the fetch scenarios, then randomized
// controls and memory contents against a behavioural model of the stage.
module tb_fetch_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0004;
   localparam int          WU       = 1;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_stage_if bus ();
   logic [31:0] mem [64];
   assign bus.imem_instr = mem[bus.imem_addr[7:2]];

   fetch_stage #(
      .RESET_PC      (RESET_PC),
      .WARMUP_CYCLES (WU),
      .NOP_INSTR     (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: warm-up edges remaining, sticky stop flags, PC and IF/ID contents.
   logic [31:0] m_pc, m_ipc, m_ip4, m_instr;
   logic        m_v, m_halt, m_mis;
   int          m_warm;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_bubble();
      m_v = 1'b0; m_ipc = 32'd0; m_ip4 = 32'd0; m_instr = NOP;
   endtask

   task automatic model_edge();
      logic [31:0] w;
      if (reset) begin
         m_pc = RESET_PC; m_warm = WU; m_halt = 1'b0; m_mis = 1'b0;
         model_bubble();
      end else if (m_halt) begin
         model_bubble();
      end else if (m_warm > 0) begin
         m_warm--;
         model_bubble();
      end else if (bus.redirect_valid) begin
         model_bubble();
         if (bus.redirect_pc % 4 != 0) begin
            m_mis = 1'b1; m_halt = 1'b1;
         end else begin
            m_pc = bus.redirect_pc;
         end
      end else if (bus.stall) begin
      end else if (bus.flush) begin
         model_bubble();
         m_pc = m_pc + 4;
      end else begin
         w = mem[m_pc[7:2]];
         m_v = 1'b1; m_ipc = m_pc; m_ip4 = m_pc + 4; m_instr = w;
         if (w == 32'h0000_0073 || w == 32'h0010_0073) m_halt = 1'b1;
         else m_pc = m_pc + 4;
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check({tag, ".addr"},  bus.imem_addr,            m_pc);
      check({tag, ".valid"}, 32'(bus.ifid_valid),      32'(m_v));
      check({tag, ".pc"},    bus.ifid_pc,              m_ipc);
      check({tag, ".pc4"},   bus.ifid_pc_plus4,        m_ip4);
      check({tag, ".instr"}, bus.ifid_instr,           m_instr);
      check({tag, ".halt"},  32'(bus.halted),          32'(m_halt));
      check({tag, ".mis"},   32'(bus.misaligned),      32'(m_mis));
   endtask

   task automatic idle_ctrl();
      bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
      mem[1]  = 32'h0195_0533;
      mem[2]  = 32'h0140_A103;
      mem[3]  = 32'h0051_7233;
      mem[4]  = 32'h0010_0073;
      mem[63] = 32'h0000_0000;
      idle_ctrl();
      reset = 1'b1;
      step("rst0");
      step("rst1");
      check("rst_addr", bus.imem_addr, RESET_PC);
      check("rst_instr", bus.ifid_instr, NOP);
      reset = 1'b0;

      // Straight-line fetch.
      step("e1");
      check("e1_valid", 32'(bus.ifid_valid), 32'd0);
      step("e2");
      check("e2_pc", bus.ifid_pc, 32'd4);
      check("e2_instr", bus.ifid_instr, 32'h0195_0533);
      step("e3");
      check("e3_instr", bus.ifid_instr, 32'h0140_A103);

      // Stall holds lw in IF/ID and the PC at 12.
      bus.stall = 1'b1;
      step("stall");
      check("stall_pc", bus.ifid_pc, 32'd8);
      check("stall_addr", bus.imem_addr, 32'd12);
      bus.stall = 1'b0;
      step("e4");
      check("e4_instr", bus.ifid_instr, 32'h0051_7233);
      check("e4_pc4", bus.ifid_pc_plus4, 32'd16);

      // Redirect wins over stall and flush.
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd4; bus.stall = 1'b1; bus.flush = 1'b1;
      step("redir");
      check("redir_valid", 32'(bus.ifid_valid), 32'd0);
      check("redir_addr", bus.imem_addr, 32'd4);
      idle_ctrl();
      step("redir_tgt");
      check("redir_tgt_instr", bus.ifid_instr, 32'h0195_0533);

      // Flush while fetching address 8.
      bus.flush = 1'b1;
      step("flush");
      check("flush_addr", bus.imem_addr, 32'd12);
      bus.flush = 1'b0;
      step("post_flush");
      check("post_flush_pc", bus.ifid_pc, 32'd12);

      // EBREAK at 16 halts with the word captured.
      step("ebreak");
      check("ebreak_instr", bus.ifid_instr, 32'h0010_0073);
      check("ebreak_halt", 32'(bus.halted), 32'd1);
      check("ebreak_addr", bus.imem_addr, 32'd16);
      step("halt_bubble");
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd8;
      step("halt_redir");
      idle_ctrl();
      reset = 1'b1;
      step("halt_rst");
      reset = 1'b0;

      // Misaligned redirect.
      step("m_warm");
      step("m_run");
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd6;
      step("mis");
      check("mis_flag", 32'(bus.misaligned), 32'd1);
      check("mis_addr", bus.imem_addr, 32'd8);
      bus.redirect_pc = 32'd8; bus.flush = 1'b1;
      step("mis_ignore");
      check("mis_ignore_valid", 32'(bus.ifid_valid), 32'd0);
      idle_ctrl();
      reset = 1'b1;
      step("mis_rst");
      check("mis_rst_flag", 32'(bus.misaligned), 32'd0);
      reset = 1'b0;

      // PC wrap at the top of the address space; the all-zero word is a valid instruction.
      step("w_warm");
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
      step("w_redir");
      idle_ctrl();
      step("w_cap");
      check("wrap_valid", 32'(bus.ifid_valid), 32'd1);
      check("wrap_pc4", bus.ifid_pc_plus4, 32'd0);
      check("wrap_addr", bus.imem_addr, 32'd0);

      // Randomized phase.
      for (int i = 0; i < 64; i++) begin
         case ($urandom_range(0, 39))
            0:       mem[i] = 32'h0000_0073;
            1:       mem[i] = 32'h0010_0073;
            2:       mem[i] = 32'h0000_0000;
            default: mem[i] = $urandom;
         endcase
         if (mem[i] == 32'h0000_0073 && $urandom_range(0, 1) == 1) mem[i] = 32'h0010_0073;
      end
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 39) == 0);
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.flush = ($urandom_range(0, 5) == 0);
         bus.redirect_valid = ($urandom_range(0, 7) == 0);
         bus.redirect_pc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 3) == 0) bus.redirect_pc[1:0] = 2'($urandom_range(1, 3));
         step("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V pipeline. Owns the program counter, drives the combinational instruction-memory read address, and registers the returned word into the IF/ID pipeline register. It accepts stall (hazard detection), flush and redirect (branch/jump resolution) controls. It also enforces a warm-up window after reset, because instruction memory only becomes valid on the first clock after reset deasserts.

## Interface
- RESET_PC, 32'h0000_0004, PC loaded on reset (byte address).
- WARMUP_CYCLES, 1, cycles held in WARM after reset deasserts; legal range 1-15.
- NOP_INSTR, 32'h0000_0013, word placed in IF/ID on a bubble (addi x0,x0,0).

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC and IF/ID (hazard detection).
- flush  in  1  squash the word fetched this cycle.
- redirect_valid  in  1  load redirect_pc into PC.
- redirect_pc  in  32  redirect target, byte address.
- imem_addr  out  32  equals PC register (combinational); byte address to instruction memory.
- imem_instr  in  32  word returned by instruction memory for imem_addr, same cycle.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  32  PC of the IF/ID instruction.
- ifid_pc_plus4  out  32  ifid_pc + 4.
- ifid_instr  out  32  IF/ID instruction word.
- halted  out  1  fetch stopped (EBREAK/ECALL or misaligned redirect); sticky until reset.
- misaligned  out  1  sticky; a redirect target had bits [1:0] != 0.

## Operation
- States:
  - WARM: PC held; IF/ID bubble; counter increments. When counter == WARMUP_CYCLES-1, go to RUN on that edge.
  - RUN: normal fetch.
  - HALT: PC held; IF/ID bubble every edge; stall, flush and redirect are ignored. Left only by reset.
- In WARM, redirect, stall and flush are ignored.
- Per-edge priority in RUN, highest first: redirect > stall > flush > normal.
- Redirect, aligned target: PC <= redirect_pc; IF/ID <= bubble, even if stall or flush is also high.
- Redirect, target[1:0] != 0: misaligned <= 1; halted <= 1; state <= HALT; PC unchanged; IF/ID <= bubble.
- Stall, no redirect: PC and all IF/ID fields hold. Flush is ignored while stall is high.
- Flush, no stall or redirect: IF/ID <= bubble; PC <= PC+4. The fetched word is discarded.
- Normal: IF/ID <= {valid=1, pc=PC, pc_plus4=PC+4, instr=imem_instr}; PC <= PC+4.
- Halt on fetch: a normal capture whose imem_instr is 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK):
  - the word is captured with valid=1;
  - PC is not incremented;
  - state <= HALT and halted <= 1 on the same edge.
- Bubble means: valid=0, instr=NOP_INSTR, pc and pc_plus4 = 0.
- Arithmetic: all PC math is 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 0. No other width extension.
- An all-zero instruction word gets no special treatment and is captured as a valid instruction.

## Timing
- Reset values:
  - PC = RESET_PC, so imem_addr = RESET_PC;
  - state = WARM, counter = 0;
  - ifid_valid = 0, ifid_instr = NOP_INSTR, ifid_pc = 0, ifid_pc_plus4 = 0;
  - halted = 0, misaligned = 0.
- Reset mid-operation (any state) restores all of the above on that edge, overriding every other input.
- Latency: with WARMUP_CYCLES=1, edge E1 after reset deasserts enters RUN. The first valid IF/ID appears after edge E2. Thereafter one instruction per cycle.
- Memory read is combinational: imem_instr is sampled at the same edge that advances PC.
- Redirect costs exactly one bubble. The target word is in IF/ID one edge after the bubble edge.
- halted and misaligned are registered; both rise on the same edge as the HALT transition.

## Test plan
- Straight-line fetch. Memory: [4]=0x01950533, [8]=0x0140A103, [12]=0x00517233. Release reset.
  - -> E1: no valid; E2: (pc 4, 0x01950533, valid); E3: (8, 0x0140A103); E4: (12, 0x00517233); pc_plus4 = pc+4 each time.
- Stall one cycle after lw is in IF/ID -> IF/ID holds (8, 0x0140A103) and imem_addr holds 12. Next edge with stall low: (12, 0x00517233).
- Redirect to 0x4 with stall and flush also high -> IF/ID bubble (valid 0, instr 0x13), PC=4. Next edge: (4, 0x01950533).
- Flush alone while imem_addr=8 -> IF/ID bubble, PC=12. Next edge: (12, 0x00517233); the word at 8 is never valid.
- Redirect to 0x6 -> misaligned=1, halted=1, PC unchanged. Further redirects and flushes are ignored; ifid_valid stays 0. Reset clears both flags and PC=RESET_PC.
- EBREAK 0x00100073 at address 16 -> captured (16, 0x00100073, valid), halted=1 on the same edge, PC stays 16. The next edge gives a bubble. Asserting reset mid-HALT returns to WARM.
